// File: rtl/sprite_collision_mixer.sv
// sprite_collision_mixer: fixed-priority pixel mixer with per-frame
// sprite/sprite and sprite/playfield collision accumulation.
// Collision flags, a frame-done strobe and a frame counter are published
// on each rising edge of vsync.
// Optional build macro SPRITE_COLLISION_STICKY_EN: published flags are
// OR-ed into the outputs and persist across frames until coll_ack.
module sprite_collision_mixer #(
    parameter int unsigned NUM_SPRITES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             display_on,
    input  logic                             vsync,
    input  logic [NUM_SPRITES-1:0]           sprite_gfx,
    input  logic [3*NUM_SPRITES-1:0]         sprite_color,
    input  logic                             playfield_gfx,
    input  logic [2:0]                       playfield_color,
    input  logic [2:0]                       bg_color,
    output logic [2:0]                       rgb,
    output logic [NUM_SPRITES-1:0]           coll_sp,
    output logic [NUM_SPRITES*NUM_SPRITES-1:0] coll_ss,
    output logic                             frame_done,
    input  logic                             coll_ack,
    output logic [7:0]                       frame_count
);

    localparam int unsigned N = NUM_SPRITES;

    typedef enum logic {
        ACCUM   = 1'b0,
        PUBLISH = 1'b1
    } frame_state_t;

    frame_state_t       state;
    logic               vsync_d;
    logic               rise;
    logic [2:0]         rgb_next;
    logic [N-1:0]       sp_hit;
    logic [N*N-1:0]     ss_hit;
    logic [N-1:0]       acc_sp;
    logic [N*N-1:0]     acc_ss;

    assign rise   = vsync & ~vsync_d;
    assign sp_hit = sprite_gfx & {N{playfield_gfx}};

    // Pixel priority: blanking, lowest-index sprite, playfield, background
    always_comb begin
        logic found;
        rgb_next = '0;
        found    = 1'b0;
        if (display_on) begin
            rgb_next = playfield_gfx ? playfield_color : bg_color;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && sprite_gfx[i]) begin
                    rgb_next = sprite_color[3*i +: 3];
                    found    = 1'b1;
                end
            end
        end
    end

    // Pairwise sprite overlap; only i<j positions are ever set
    always_comb begin
        ss_hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = i + 1; j < N; j++) begin
                ss_hit[i*N+j] = sprite_gfx[i] & sprite_gfx[j];
            end
        end
    end

    // Registered mixer output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_next;
        end
    end

    // Frame FSM: accumulate during ACCUM, publish for one cycle after vsync rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ACCUM;
            vsync_d     <= 1'b0;
            acc_sp      <= '0;
            acc_ss      <= '0;
            coll_sp     <= '0;
            coll_ss     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            vsync_d    <= vsync;
            frame_done <= 1'b0;
            case (state)
                ACCUM: begin
                    // The pixel coincident with rise still lands in the closing frame
                    if (display_on) begin
                        acc_sp <= acc_sp | sp_hit;
                        acc_ss <= acc_ss | ss_hit;
                    end
                    if (coll_ack) begin
                        coll_sp <= '0;
                        coll_ss <= '0;
                    end
                    if (rise) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
`ifdef SPRITE_COLLISION_STICKY_EN
                    // Ack here acts as clear-then-OR so the new frame's hits survive
                    if (coll_ack) begin
                        coll_sp <= acc_sp;
                        coll_ss <= acc_ss;
                    end else begin
                        coll_sp <= coll_sp | acc_sp;
                        coll_ss <= coll_ss | acc_ss;
                    end
`else
                    // Publish wins over a coincident ack
                    coll_sp <= acc_sp;
                    coll_ss <= acc_ss;
`endif
                    acc_sp      <= '0;
                    acc_ss      <= '0;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    state       <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_collision_mixer.sv
// Directed self-checking bench for sprite_collision_mixer (NUM_SPRITES=4).
// Expectations follow SPRITE_COLLISION_STICKY_EN when it is defined.
module tb_sprite_collision_mixer;

    logic        clk;
    logic        reset;
    logic        display_on;
    logic        vsync;
    logic [3:0]  sprite_gfx;
    logic [11:0] sprite_color;
    logic        playfield_gfx;
    logic [2:0]  playfield_color;
    logic [2:0]  bg_color;
    logic [2:0]  rgb;
    logic [3:0]  coll_sp;
    logic [15:0] coll_ss;
    logic        frame_done;
    logic        coll_ack;
    logic [7:0]  frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_collision_mixer #(.NUM_SPRITES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .display_on      (display_on),
        .vsync           (vsync),
        .sprite_gfx      (sprite_gfx),
        .sprite_color    (sprite_color),
        .playfield_gfx   (playfield_gfx),
        .playfield_color (playfield_color),
        .bg_color        (bg_color),
        .rgb             (rgb),
        .coll_sp         (coll_sp),
        .coll_ss         (coll_ss),
        .frame_done      (frame_done),
        .coll_ack        (coll_ack),
        .frame_count     (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // sprite3=111, sprite2=011, sprite1=101, sprite0=010
        sprite_color    = {3'b111, 3'b011, 3'b101, 3'b010};
        playfield_color = 3'b110;
        bg_color        = 3'b001;
        display_on      = 1'b0;
        vsync           = 1'b0;
        sprite_gfx      = 4'b0000;
        playfield_gfx   = 1'b0;
        coll_ack        = 1'b0;
        reset           = 1'b0;
        #12;
        chk("reset_rgb", {29'd0, rgb}, 32'd0);
        chk("reset_coll_sp", {28'd0, coll_sp}, 32'd0);
        chk("reset_coll_ss", {16'd0, coll_ss}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset_frame_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b1;

        // Background pixel
        display_on = 1'b1;
        step();
        chk("bg_rgb", {29'd0, rgb}, 32'h1);
        chk("bg_frame_count", {24'd0, frame_count}, 32'd0);

        // Sprites 1 and 2 over the playfield
        sprite_gfx    = 4'b0110;
        playfield_gfx = 1'b1;
        step();
        chk("s12_rgb", {29'd0, rgb}, 32'h5);
        display_on    = 1'b0;
        sprite_gfx    = 4'b0000;
        playfield_gfx = 1'b0;
        vsync         = 1'b1;
        step();
        chk("blank_rgb", {29'd0, rgb}, 32'h0);
        chk("f1_pre_done", {31'd0, frame_done}, 32'd0);
        step();
        chk("f1_done", {31'd0, frame_done}, 32'd1);
        chk("f1_coll_sp", {28'd0, coll_sp}, 32'h6);
        chk("f1_coll_ss", {16'd0, coll_ss}, 32'h40);
        chk("f1_frame_count", {24'd0, frame_count}, 32'd1);
        // vsync held high: no further publish
        for (int k = 0; k < 3; k++) begin
            step();
            chk("held_vsync_done", {31'd0, frame_done}, 32'd0);
            chk("held_vsync_count", {24'd0, frame_count}, 32'd1);
        end

        // Overlaps during blanking are ignored; clean frame
        vsync         = 1'b0;
        sprite_gfx    = 4'b0110;
        playfield_gfx = 1'b1;
        step();
        chk("blank_ovl_rgb", {29'd0, rgb}, 32'h0);
        sprite_gfx    = 4'b0000;
        playfield_gfx = 1'b0;
        vsync         = 1'b1;
        step();
        step();
        chk("f2_done", {31'd0, frame_done}, 32'd1);
        chk("f2_frame_count", {24'd0, frame_count}, 32'd2);
`ifdef SPRITE_COLLISION_STICKY_EN
        chk("f2_coll_sp_sticky", {28'd0, coll_sp}, 32'h6);
        chk("f2_coll_ss_sticky", {16'd0, coll_ss}, 32'h40);
`else
        chk("f2_coll_sp", {28'd0, coll_sp}, 32'h0);
        chk("f2_coll_ss", {16'd0, coll_ss}, 32'h0);
`endif
        coll_ack = 1'b1;
        step();
        coll_ack = 1'b0;
        chk("f2_ack_coll_sp", {28'd0, coll_sp}, 32'h0);
        chk("f2_ack_coll_ss", {16'd0, coll_ss}, 32'h0);

        // Ack coincident with publish: new data is kept
        vsync         = 1'b0;
        display_on    = 1'b1;
        sprite_gfx    = 4'b0001;
        playfield_gfx = 1'b1;
        step();
        display_on    = 1'b0;
        sprite_gfx    = 4'b0000;
        playfield_gfx = 1'b0;
        vsync         = 1'b1;
        step();
        coll_ack = 1'b1;
        step();
        coll_ack = 1'b0;
        chk("f3_ack_pub_done", {31'd0, frame_done}, 32'd1);
        chk("f3_ack_pub_coll_sp", {28'd0, coll_sp}, 32'h1);
        chk("f3_ack_pub_coll_ss", {16'd0, coll_ss}, 32'h0);
        chk("f3_frame_count", {24'd0, frame_count}, 32'd3);
        coll_ack = 1'b1;
        step();
        coll_ack = 1'b0;
        chk("f3_accum_ack_sp", {28'd0, coll_sp}, 32'h0);

        // frame_count wrap: 253 more rises brings 3 back to 0
        for (int k = 0; k < 253; k++) begin
            vsync = 1'b0;
            step();
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            step();
        end
        chk("wrap_frame_count", {24'd0, frame_count}, 32'd0);
        chk("wrap_done", {31'd0, frame_done}, 32'd1);

        // Publish sprites 0/1 on playfield, then reset mid-frame
        display_on    = 1'b1;
        sprite_gfx    = 4'b0011;
        playfield_gfx = 1'b1;
        step();
        chk("s01_rgb", {29'd0, rgb}, 32'h2);
        display_on = 1'b0;
        vsync      = 1'b1;
        step();
        step();
        chk("f5_coll_sp", {28'd0, coll_sp}, 32'h3);
        chk("f5_coll_ss", {16'd0, coll_ss}, 32'h2);
        chk("f5_frame_count", {24'd0, frame_count}, 32'd1);
        vsync      = 1'b0;
        display_on = 1'b1;
        step();
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_rgb", {29'd0, rgb}, 32'h0);
        chk("midrst_coll_sp", {28'd0, coll_sp}, 32'h0);
        chk("midrst_coll_ss", {16'd0, coll_ss}, 32'h0);
        chk("midrst_frame_count", {24'd0, frame_count}, 32'd0);
        chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        #2;
        reset         = 1'b1;
        sprite_gfx    = 4'b0000;
        playfield_gfx = 1'b0;
        step();
        display_on = 1'b0;
        vsync      = 1'b1;
        step();
        step();
        chk("postrst_done", {31'd0, frame_done}, 32'd1);
        chk("postrst_coll_sp", {28'd0, coll_sp}, 32'h0);
        chk("postrst_coll_ss", {16'd0, coll_ss}, 32'h0);
        chk("postrst_frame_count", {24'd0, frame_count}, 32'd1);

        // Priority patterns (accumulation effects no longer checked)
        vsync         = 1'b0;
        display_on    = 1'b1;
        sprite_gfx    = 4'b1111;
        playfield_gfx = 1'b1;
        step();
        chk("prio_all_rgb", {29'd0, rgb}, 32'h2);
        sprite_gfx = 4'b1000;
        step();
        chk("prio_s3_rgb", {29'd0, rgb}, 32'h7);
        sprite_gfx = 4'b0000;
        step();
        chk("prio_pf_rgb", {29'd0, rgb}, 32'h6);
        sprite_gfx = 4'b1100;
        step();
        chk("prio_s23_rgb", {29'd0, rgb}, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_collision_mixer.md
Name: sprite_collision_mixer

Overview:
- Downstream of the tank controllers and the playfield generator; consumes per-pixel sprite gfx bits and the playfield bit.
- Produces the final registered 3-bit rgb with fixed priority.
- Accumulates per-frame sprite/sprite and sprite/playfield collision flags and publishes them once per frame at vsync, with a frame-done strobe and acknowledge clear.

Parameters:
- NUM_SPRITES, 4, number of sprite gfx inputs (2..8); index 0 has highest priority.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- display_on  in  1  from hvsync_generator; high in the visible area
- vsync  in  1  from hvsync_generator; the rising edge marks the frame boundary
- sprite_gfx  in  NUM_SPRITES  per-sprite pixel-on bits
- sprite_color  in  3*NUM_SPRITES  {b,g,r} per sprite; sprite i at [3i+2:3i]
- playfield_gfx  in  1  playfield pixel-on bit
- playfield_color  in  3  {b,g,r} for the playfield
- bg_color  in  3  {b,g,r} background colour
- rgb  out  3  mixed pixel {b,g,r}, registered
- coll_sp  out  NUM_SPRITES  bit i: sprite i hit the playfield last frame
- coll_ss  out  NUM_SPRITES*NUM_SPRITES  bit i*NUM_SPRITES+j (i<j): sprites i and j overlapped; other bits are always 0
- frame_done  out  1  one-cycle pulse when coll_* update
- coll_ack  in  1  clears coll_sp/coll_ss
- frame_count  out  8  count of completed frames; wraps 255->0

Behaviour:
- Reset (reset low, asynchronous): rgb=0, coll_sp=0, coll_ss=0, frame_done=0, frame_count=0, accumulators=0, vsync_d=0.
- Mixer, 1-cycle latency. The value registered into rgb follows the first matching rule:
  - display_on=0 -> 0.
  - Else, if any sprite_gfx bit is set -> the colour of the lowest set index.
  - Else, if playfield_gfx -> playfield_color.
  - Else -> bg_color.
- Accumulation happens only when display_on=1:
  - acc_sp[i] |= sprite_gfx[i] & playfield_gfx.
  - acc_ss[i*N+j] |= sprite_gfx[i] & sprite_gfx[j] for all i<j.
- Edge detect: vsync_d registers vsync. rise = vsync & ~vsync_d. Only the rising edge acts; a held-high vsync does nothing further.
- Frame states:
  - ACCUM: accumulate.
  - On rise -> PUBLISH for one cycle.
  - PUBLISH actions: coll_sp<=acc_sp, coll_ss<=acc_ss, acc_*<=0, frame_done<=1, frame_count<=frame_count+1.
  - Accumulation is suppressed during the PUBLISH cycle. It cannot occur anyway because display_on=0 during vsync.
  - Then return to ACCUM. frame_done is high for exactly one cycle per rising edge.
- coll_ack: in ACCUM, coll_ack=1 clears coll_sp and coll_ss on the next edge.
- Simultaneous coll_ack and PUBLISH: publish wins. New data is loaded, not cleared, and the ack is dropped.
- Pixel coincident with rise: counted in the frame being closed, because accumulation and the edge detect sample the same cycle.
- frame_count is 8-bit modular.
- Reset asserted mid-frame: everything clears immediately. The first rise after release publishes only pixels seen since release.
- Width rule: coll_ss bits with i>=j are tied to 0, never X.

Optional Feature:
- Macro: SPRITE_COLLISION_STICKY_EN.
- Defined: PUBLISH ORs into the outputs instead of loading them (coll_sp<=coll_sp|acc_sp, same for coll_ss). Flags persist across frames until coll_ack. Ack coincident with PUBLISH loads acc_* (clear-then-OR), so the new frame's hits survive.
- Undefined: outputs are replaced every frame, as described in Behaviour.

Test Plan:
- Reset release, display_on=1, no gfx, bg_color=3'b001 -> rgb=001 one cycle after inputs. coll_*=0, frame_count=0.
- sprite_gfx=4'b0110, sprite1 colour 3'b101, sprite2 colour 3'b011, playfield_gfx=1 -> rgb=101. After vsync rise: coll_sp=4'b0110, coll_ss bit 6 (1*4+2)=1, frame_done pulse exactly 1 cycle, frame_count=1.
- Same overlaps as the previous case but display_on=0 -> rgb=000. After vsync: coll_sp=0, coll_ss=0.
- Publish a hit frame, then a clean frame -> the second frame_done shows coll_*=0. With SPRITE_COLLISION_STICKY_EN the flags are still set until coll_ack=1, then 0 next cycle.
- coll_ack asserted on the PUBLISH cycle with acc_sp=4'b0001 -> coll_sp=4'b0001 (not cleared), in both macro builds.
- 256 vsync rises -> frame_count returns to 0. Pulsing reset low mid-frame -> all outputs are 0 asynchronously, before the next clk edge.
